// File: rtl/exec_ctrl_core.sv
// Decode, execute and next-PC stage of the 8-bit single-cycle CPU.
// Combinational decode/ALU around a single PC register that advances, branches or stalls.
module exec_ctrl_core (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    input  logic [7:0]  READDATA,
    input  logic        busywait,
    output logic [31:0] pc,
    output logic [7:0]  ALURESULT,
    output logic [7:0]  WRITEDATA,
    output logic        WRITEENABLE,
    output logic        mem_read,
    output logic        mem_write
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;

    typedef enum logic [1:0] {ALU_FWD, ALU_ADD, ALU_AND, ALU_OR} alu_op_t;

    logic [7:0]  opcode;
    logic [7:0]  imm;
    logic        use_imm;
    logic        negate_b;
    logic        is_j;
    logic        is_beq;
    logic        is_bne;
    logic        we_dec;
    logic        mr_dec;
    logic        mw_dec;
    alu_op_t     alu_op;
    logic [7:0]  b_sel;
    logic [7:0]  b_op;
    logic        zero;
    logic        take;
    logic [31:0] offset;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        unused_bits;

    assign opcode = INSTRUCTION[31:24];
    assign imm    = INSTRUCTION[7:0];
    // Register indices are consumed by the register file, not here.
    assign unused_bits = ^{INSTRUCTION[15:8]};

    always_comb begin
        use_imm  = 1'b0;
        negate_b = 1'b0;
        is_j     = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        we_dec   = 1'b0;
        mr_dec   = 1'b0;
        mw_dec   = 1'b0;
        alu_op   = ALU_FWD;
        case (opcode)
            OP_LOADI: begin use_imm = 1'b1; we_dec = 1'b1; end
            OP_MOV:   we_dec = 1'b1;
            OP_ADD:   begin alu_op = ALU_ADD; we_dec = 1'b1; end
            OP_SUB:   begin alu_op = ALU_ADD; negate_b = 1'b1; we_dec = 1'b1; end
            OP_AND:   begin alu_op = ALU_AND; we_dec = 1'b1; end
            OP_OR:    begin alu_op = ALU_OR; we_dec = 1'b1; end
            OP_J:     is_j = 1'b1;
            OP_BEQ:   begin alu_op = ALU_ADD; negate_b = 1'b1; is_beq = 1'b1; end
            OP_LWD:   begin we_dec = 1'b1; mr_dec = 1'b1; end
            OP_LWI:   begin use_imm = 1'b1; we_dec = 1'b1; mr_dec = 1'b1; end
            OP_SWD:   mw_dec = 1'b1;
            OP_SWI:   begin use_imm = 1'b1; mw_dec = 1'b1; end
            OP_BNE:   begin alu_op = ALU_ADD; negate_b = 1'b1; is_bne = 1'b1; end
            default:  ;
        endcase
    end

    assign b_sel = use_imm ? imm : REGOUT2;
    assign b_op  = negate_b ? (~b_sel + 8'd1) : b_sel;

    always_comb begin
        case (alu_op)
            ALU_ADD: ALURESULT = REGOUT1 + b_op;
            ALU_AND: ALURESULT = REGOUT1 & b_op;
            ALU_OR:  ALURESULT = REGOUT1 | b_op;
            default: ALURESULT = b_op;
        endcase
    end

    assign zero = (ALURESULT == 8'h00);

    // Side-effecting controls are suppressed while reset is held.
    assign WRITEENABLE = we_dec & RESET;
    assign mem_read    = mr_dec & RESET;
    assign mem_write   = mw_dec & RESET;
    assign WRITEDATA   = mem_read ? READDATA : ALURESULT;

    assign offset   = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc_plus4 + offset;
    assign take     = is_j | (is_beq & zero) | (is_bne & ~zero);
    assign next_pc  = take ? target : pc_plus4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            pc <= 32'd0;
        else if (!busywait)
            pc <= next_pc;
    end

endmodule

// File: tb/tb_exec_ctrl_core.sv
// Directed self-checking bench for exec_ctrl_core with hand-computed expectations.
module tb_exec_ctrl_core;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [7:0]  REGOUT1;
    logic [7:0]  REGOUT2;
    logic [7:0]  READDATA;
    logic        busywait;
    logic [31:0] pc;
    logic [7:0]  ALURESULT;
    logic [7:0]  WRITEDATA;
    logic        WRITEENABLE;
    logic        mem_read;
    logic        mem_write;

    int checks = 0;
    int errors = 0;

    exec_ctrl_core dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .READDATA    (READDATA),
        .busywait    (busywait),
        .pc          (pc),
        .ALURESULT   (ALURESULT),
        .WRITEDATA   (WRITEDATA),
        .WRITEENABLE (WRITEENABLE),
        .mem_read    (mem_read),
        .mem_write   (mem_write)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] dest,
                                       input logic [7:0] lo);
        return {op, dest, 8'h00, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reset then two NOPs: leaves pc at 8.
    task automatic goto_pc8();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        INSTRUCTION = mk(8'hFF, 8'h00, 8'h00);
        tick();
        tick();
    endtask

    initial begin
        RESET       = 1'b0;
        INSTRUCTION = mk(8'h08, 8'h00, 8'h00);
        REGOUT1     = 8'h00;
        REGOUT2     = 8'h00;
        READDATA    = 8'h00;
        busywait    = 1'b0;

        // 1. reset state while clocking
        tick();
        tick();
        check("rst_pc", pc, 32'd0);
        check("rst_we", {31'd0, WRITEENABLE}, 32'd0);
        check("rst_mr", {31'd0, mem_read}, 32'd0);
        INSTRUCTION = mk(8'h0A, 8'h00, 8'h00);
        #1;
        check("rst_mw", {31'd0, mem_write}, 32'd0);

        @(negedge CLK);
        RESET = 1'b1;
        INSTRUCTION = mk(8'hFF, 8'h00, 8'h00);
        #1;
        check("nop_we", {31'd0, WRITEENABLE}, 32'd0);
        tick(); check("pc_4", pc, 32'd4);
        tick(); check("pc_8", pc, 32'd8);
        tick(); check("pc_12", pc, 32'd12);

        // 2. add / sub
        INSTRUCTION = mk(8'h02, 8'h01, 8'h02);
        REGOUT1 = 8'h7F; REGOUT2 = 8'h02;
        #1;
        check("add_res", {24'd0, ALURESULT}, 32'h81);
        check("add_we", {31'd0, WRITEENABLE}, 32'd1);
        check("add_wd", {24'd0, WRITEDATA}, 32'h81);
        INSTRUCTION = mk(8'h03, 8'h01, 8'h02);
        REGOUT1 = 8'h05; REGOUT2 = 8'h05;
        #1;
        check("sub_zero", {24'd0, ALURESULT}, 32'h00);
        REGOUT1 = 8'h03; REGOUT2 = 8'h05;
        #1;
        check("sub_neg", {24'd0, ALURESULT}, 32'hFE);

        // 3. loadi / mov / and / or
        INSTRUCTION = mk(8'h00, 8'h01, 8'hAB);
        REGOUT2 = 8'h11;
        #1;
        check("loadi_res", {24'd0, ALURESULT}, 32'hAB);
        INSTRUCTION = mk(8'h01, 8'h01, 8'h02);
        REGOUT2 = 8'h5A;
        #1;
        check("mov_res", {24'd0, ALURESULT}, 32'h5A);
        INSTRUCTION = mk(8'h04, 8'h01, 8'h02);
        REGOUT1 = 8'hF0; REGOUT2 = 8'h3C;
        #1;
        check("and_res", {24'd0, ALURESULT}, 32'h30);
        INSTRUCTION = mk(8'h05, 8'h01, 8'h02);
        #1;
        check("or_res", {24'd0, ALURESULT}, 32'hFC);

        // 4. branches from pc=8
        goto_pc8();
        check("pc8_setup", pc, 32'd8);
        INSTRUCTION = mk(8'h07, 8'hFE, 8'h02);
        REGOUT1 = 8'h03; REGOUT2 = 8'h03;
        #1;
        check("beq_we", {31'd0, WRITEENABLE}, 32'd0);
        tick(); check("beq_taken", pc, 32'd4);
        goto_pc8();
        INSTRUCTION = mk(8'h07, 8'hFE, 8'h02);
        REGOUT1 = 8'h03; REGOUT2 = 8'h04;
        tick(); check("beq_not", pc, 32'd12);
        goto_pc8();
        INSTRUCTION = mk(8'h0C, 8'hFE, 8'h02);
        REGOUT1 = 8'h03; REGOUT2 = 8'h03;
        tick(); check("bne_not", pc, 32'd12);
        goto_pc8();
        INSTRUCTION = mk(8'h0C, 8'hFE, 8'h02);
        REGOUT1 = 8'h03; REGOUT2 = 8'h04;
        tick(); check("bne_taken", pc, 32'd4);
        goto_pc8();
        INSTRUCTION = mk(8'h06, 8'h02, 8'h00);
        tick(); check("j_fwd", pc, 32'd20);
        // backward jump from 20: 20+4-512 wraps below zero
        INSTRUCTION = mk(8'h06, 8'h80, 8'h00);
        tick(); check("j_wrap", pc, 32'hFFFF_FE18);

        // 5. lwd and stall
        goto_pc8();
        INSTRUCTION = mk(8'h08, 8'h01, 8'h02);
        REGOUT2 = 8'h10; READDATA = 8'h55;
        #1;
        check("lwd_mr", {31'd0, mem_read}, 32'd1);
        check("lwd_res", {24'd0, ALURESULT}, 32'h10);
        check("lwd_wd", {24'd0, WRITEDATA}, 32'h55);
        check("lwd_we", {31'd0, WRITEENABLE}, 32'd1);
        busywait = 1'b1;
        tick(); check("stall_1", pc, 32'd8);
        tick(); check("stall_2", pc, 32'd8);
        tick(); check("stall_3", pc, 32'd8);
        check("stall_res", {24'd0, ALURESULT}, 32'h10);
        busywait = 1'b0;
        tick(); check("stall_rel", pc, 32'd12);

        // 6. swi, then reset mid-stall
        INSTRUCTION = mk(8'h0B, 8'h00, 8'h20);
        REGOUT2 = 8'h99;
        #1;
        check("swi_mw", {31'd0, mem_write}, 32'd1);
        check("swi_we", {31'd0, WRITEENABLE}, 32'd0);
        check("swi_mr", {31'd0, mem_read}, 32'd0);
        check("swi_res", {24'd0, ALURESULT}, 32'h20);
        busywait = 1'b1;
        tick(); check("swi_stall", pc, 32'd12);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("async_pc", pc, 32'd0);
        check("async_mw", {31'd0, mem_write}, 32'd0);
        RESET = 1'b1;
        busywait = 1'b0;
        tick(); check("post_rst", pc, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
